// File: rtl/seg7_scan_capture.sv
// ----------------------------------------------------------------------------
// seg7_scan_capture
//
// Receiving end of a multiplexed 8-digit, active-low 7-segment display bus.
// The block watches the digit enables and segment lines and waits for each
// {Seg,Display} pattern to settle. It then decodes the shown glyph back to a
// hex nibble and rebuilds the 32-bit word the display was showing. It serves
// as an on-board loopback checker and as a bench monitor.
//
// Ports
//   clk          in   1   system clock
//   reset        in   1   asynchronous reset, active low
//   Seg          in   8   digit enables, active low; bit i selects digit i
//   Display      in   7   segments, active low, bit order {g,f,e,d,c,b,a}
//   value        out  32  last completed frame, digit i in bits [4i+3:4i]
//   blank_mask   out  8   digits of the last frame that were blank
//   frame_valid  out  1   one-cycle pulse when value/blank_mask update
//   decode_err   out  1   one-cycle pulse when a stable pattern is rejected
//   err_digit    out  3   digit index of the most recent decode error
//   stalled      out  1   high after TIMEOUT cycles without a capture
//
// Parameters
//   STABLE_CYCLES  a pattern must hold this many cycles before it is used (>=2)
//   TIMEOUT        idle cycles before stalled rises and the partial frame drops
// ----------------------------------------------------------------------------
module seg7_scan_capture #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  Seg,
  input  logic [6:0]  Display,
  output logic [31:0] value,
  output logic [7:0]  blank_mask,
  output logic        frame_valid,
  output logic        decode_err,
  output logic [2:0]  err_digit,
  output logic        stalled
);

  localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);

  localparam logic [STAB_W-1:0] STAB_EVAL = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CYCLES);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TIMEOUT);

  // Outcome of evaluating one settled pattern.
  typedef enum logic [1:0] {
    EV_NONE,
    EV_CAPTURE,
    EV_ERROR
  } eval_e;

  // Result of decoding one segment code.
  typedef struct packed {
    logic       valid;
    logic       blank;
    logic [3:0] nibble;
  } digit_t;

  // Maps an active-low {g..a} code to a nibble. An all-off code is a
  // legal blank digit, which reads as nibble 0.
  function automatic digit_t decode_segments(input logic [6:0] code);
    digit_t d;
    d.valid  = 1'b1;
    d.blank  = 1'b0;
    d.nibble = 4'h0;
    case (code)
      7'h40:   d.nibble = 4'h0;
      7'h79:   d.nibble = 4'h1;
      7'h24:   d.nibble = 4'h2;
      7'h30:   d.nibble = 4'h3;
      7'h19:   d.nibble = 4'h4;
      7'h12:   d.nibble = 4'h5;
      7'h02:   d.nibble = 4'h6;
      7'h78:   d.nibble = 4'h7;
      7'h00:   d.nibble = 4'h8;
      7'h10:   d.nibble = 4'h9;
      7'h08:   d.nibble = 4'hA;
      7'h03:   d.nibble = 4'hB;
      7'h46:   d.nibble = 4'hC;
      7'h21:   d.nibble = 4'hD;
      7'h06:   d.nibble = 4'hE;
      7'h0E:   d.nibble = 4'hF;
      7'h7F:   d.blank  = 1'b1;
      default: d.valid  = 1'b0;
    endcase
    return d;
  endfunction

  // --------------------------------------------------------------------------
  // Input synchroniser. Both stages carry the full 15-bit {Seg,Display} bus.
  // Only sync2_q is treated as the synchronised value. sync1_q is the value
  // sync2_q will take next. Comparing the two tells us whether the pattern is
  // about to change.
  // --------------------------------------------------------------------------
  logic [14:0] sync1_q, sync2_q;

  // NOTE: sequential state is assigned with <= only, so every flop samples
  // the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {Seg, Display};
      sync2_q <= sync1_q;
    end
  end

  logic [7:0] seg_s;
  logic [6:0] disp_s;
  assign seg_s  = sync2_q[14:7];
  assign disp_s = sync2_q[6:0];

  // --------------------------------------------------------------------------
  // Stability counter. It restarts when the synchronised pattern is about to
  // change and saturates at STABLE_CYCLES. The evaluation edge is the single
  // edge where the count is about to go from STABLE_CYCLES-1 to
  // STABLE_CYCLES. Saturation ensures a held pattern is never evaluated twice.
  // The clause that the pattern is about to stay the same requires the pins
  // to have shown this pattern for STABLE_CYCLES+1 consecutive samples.
  // --------------------------------------------------------------------------
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic              pattern_same;
  logic              evaluate;

  assign pattern_same = (sync1_q == sync2_q);
  assign evaluate     = pattern_same && (stab_cnt_q == STAB_EVAL);

  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    stab_cnt_d = stab_cnt_q;
    if (!pattern_same) begin
      stab_cnt_d = '0;
    end else if (stab_cnt_q != STAB_MAX) begin
      stab_cnt_d = stab_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stab_cnt_q <= '0;
    end else begin
      stab_cnt_q <= stab_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Classification of the settled pattern.
  // --------------------------------------------------------------------------
  eval_e      ev;
  digit_t     dec;
  logic [2:0] low_idx;

  always_comb begin
    // Search downwards so that the lowest enabled digit wins.
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!seg_s[i]) begin
        low_idx = 3'(i);
      end
    end
  end

  always_comb begin
    ev  = EV_NONE;
    dec = decode_segments(disp_s);
    // No digit enabled means the driver is between digits: not an error.
    if (evaluate && (seg_s != 8'hFF)) begin
      if ($onehot(~seg_s) && dec.valid) begin
        ev = EV_CAPTURE;
      end else begin
        ev = EV_ERROR;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame assembly, error reporting and idle timeout.
  // --------------------------------------------------------------------------
  logic [31:0]     shadow_q, shadow_d;
  logic [7:0]      shadow_blank_q, shadow_blank_d;
  logic [7:0]      mask_q, mask_d;
  logic [31:0]     value_q, value_d;
  logic [7:0]      blank_mask_q, blank_mask_d;
  logic            frame_valid_q, frame_valid_d;
  logic            decode_err_q, decode_err_d;
  logic [2:0]      err_digit_q, err_digit_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            stalled_q, stalled_d;

  always_comb begin
    shadow_d       = shadow_q;
    shadow_blank_d = shadow_blank_q;
    mask_d         = mask_q;
    value_d        = value_q;
    blank_mask_d   = blank_mask_q;
    frame_valid_d  = 1'b0;
    decode_err_d   = 1'b0;
    err_digit_d    = err_digit_q;
    to_cnt_d       = to_cnt_q;
    stalled_d      = stalled_q;

    if (ev == EV_CAPTURE) begin
      shadow_d[{low_idx, 2'b00} +: 4] = dec.nibble;
      shadow_blank_d[low_idx]         = dec.blank;
      mask_d[low_idx]                 = 1'b1;
      to_cnt_d                        = '0;
      stalled_d                       = 1'b0;
      // The completing digit is published in the same edge, so publish
      // the next-state shadow rather than the registered one.
      if (mask_d == 8'hFF) begin
        value_d       = shadow_d;
        blank_mask_d  = shadow_blank_d;
        frame_valid_d = 1'b1;
        mask_d        = '0;
      end
    end else begin
      // A capture takes priority over a timeout on the same edge. A decode
      // error is not a capture, so idle time keeps accruing through it.
      if (to_cnt_q != TO_MAX) begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
      if (to_cnt_q == TO_LAST) begin
        stalled_d = 1'b1;
        mask_d    = '0;
      end
    end

    if (ev == EV_ERROR) begin
      decode_err_d = 1'b1;
      err_digit_d  = low_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q       <= '0;
      shadow_blank_q <= '0;
      mask_q         <= '0;
      value_q        <= '0;
      blank_mask_q   <= '0;
      frame_valid_q  <= 1'b0;
      decode_err_q   <= 1'b0;
      err_digit_q    <= '0;
      to_cnt_q       <= '0;
      stalled_q      <= 1'b0;
    end else begin
      shadow_q       <= shadow_d;
      shadow_blank_q <= shadow_blank_d;
      mask_q         <= mask_d;
      value_q        <= value_d;
      blank_mask_q   <= blank_mask_d;
      frame_valid_q  <= frame_valid_d;
      decode_err_q   <= decode_err_d;
      err_digit_q    <= err_digit_d;
      to_cnt_q       <= to_cnt_d;
      stalled_q      <= stalled_d;
    end
  end

  assign value       = value_q;
  assign blank_mask  = blank_mask_q;
  assign frame_valid = frame_valid_q;
  assign decode_err  = decode_err_q;
  assign err_digit   = err_digit_q;
  assign stalled     = stalled_q;

endmodule
